mmio_uart: RTL and testbench

//  Memory-mapped UART transmitter on the processor data port, alongside dmem.

---
 rtl/mmio_uart_if.sv | 23 ++
 rtl/mmio_uart.sv | 199 +++++++++++++++++++
 tb/tb_mmio_uart.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/mmio_uart_if.sv
// Processor data-port bundle between the core (master) and the UART window (slave).
//  ip_data_addr/wr/mask/from_proc/rd : address, write strobe, byte lanes, write data, read strobe
//  op_sel/op_data_valid/op_data_to_proc : window hit, read valid, read data (all combinational)
interface mmio_uart_if;
  logic [31:0] ip_data_addr;
  logic        ip_data_wr;
  logic [3:0]  ip_data_mask;
  logic [31:0] ip_data_from_proc;
  logic        ip_data_rd;
  logic        op_sel;
  logic        op_data_valid;
  logic [31:0] op_data_to_proc;

  modport master (
    output ip_data_addr, ip_data_wr, ip_data_mask, ip_data_from_proc, ip_data_rd,
    input  op_sel, op_data_valid, op_data_to_proc
  );

  modport slave (
    input  ip_data_addr, ip_data_wr, ip_data_mask, ip_data_from_proc, ip_data_rd,
    output op_sel, op_data_valid, op_data_to_proc
  );
endinterface

// File: rtl/mmio_uart.sv
// Memory-mapped 8N1 UART transmitter with a TX FIFO and programmable bit period.
//  clk, reset (sync, active high)
//  bus        : processor data port (slave side), window of 3 words at BASE_ADDR
//               +0 TXDATA (WO), +4 STATUS, +8 DIVISOR
//  op_uart_tx : serial line, idles high
module mmio_uart #(
  parameter logic [31:0] BASE_ADDR       = 32'h0000_0054,
  parameter int unsigned FIFO_DEPTH      = 8,
  parameter logic [15:0] DEFAULT_DIVISOR = 16'd433
) (
  input  logic        clk,
  input  logic        reset,
  mmio_uart_if.slave  bus,
  output logic        op_uart_tx
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_e;

  // ---------------- address decode ----------------
  logic [31:0] offset;
  logic        in_win;
  logic        aligned;
  logic [1:0]  word;
  logic        wr_en;
  logic        push;
  logic        ovf_clr;
  logic        div_wr;

  // Offset wraps to a large value below BASE, so one compare covers both bounds.
  assign offset  = bus.ip_data_addr - BASE_ADDR;
  assign in_win  = offset < 32'd12;
  assign aligned = bus.ip_data_addr[1:0] == 2'b00;
  assign word    = offset[3:2];
  assign wr_en   = in_win & aligned & bus.ip_data_wr;
  assign push    = wr_en & (word == 2'd0) & bus.ip_data_mask[0];
  assign ovf_clr = wr_en & (word == 2'd1) & bus.ip_data_mask[0] & bus.ip_data_from_proc[3];
  assign div_wr  = wr_en & (word == 2'd2);

  // ---------------- state ----------------
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic [15:0]      div_q, div_d;
  state_e           state_q, state_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic [2:0]       idx_q, idx_d;
  logic             tx_q, tx_d;

  logic full, empty, pop, push_ok, bit_end, busy;
  logic [7:0] head;

  assign full    = count_q == CNT_W'(FIFO_DEPTH);
  assign empty   = count_q == '0;
  assign busy    = state_q != ST_IDLE;
  assign pop     = (state_q == ST_IDLE) & ~empty;
  // A pop in the same cycle frees the slot, so a push at full is still accepted.
  assign push_ok = push & (~full | pop);
  assign head    = mem_q[rd_ptr_q];
  assign bit_end = cnt_q == 16'd0;

  // FIFO pointers, count, sticky overflow and divisor
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    div_d    = div_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (ovf_clr) ovf_d = 1'b0;
    // Set after clear so a simultaneous drop keeps the flag set.
    if (push & ~push_ok) ovf_d = 1'b1;
    if (div_wr) begin
      if (bus.ip_data_mask[0]) div_d[7:0]  = bus.ip_data_from_proc[7:0];
      if (bus.ip_data_mask[1]) div_d[15:8] = bus.ip_data_from_proc[15:8];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      div_q    <= DEFAULT_DIVISOR;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      div_q    <= div_d;
    end
  end

  // FIFO storage; contents are don't-care while the count says empty
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= bus.ip_data_from_proc[7:0];
  end

  // TX FSM: state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // TX FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (~empty) state_d = ST_START;
      ST_START: if (bit_end) state_d = ST_DATA;
      ST_DATA:  if (bit_end && idx_q == 3'd7) state_d = ST_STOP;
      ST_STOP:  if (bit_end) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // TX FSM: line level (registered one cycle later for a glitch-free pin)
  always_comb begin
    tx_d = 1'b1;
    case (state_q)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shift_q[0];
      default:  tx_d = 1'b1;
    endcase
  end

  // Bit timer and shifter; the divisor is re-read at every bit boundary
  always_comb begin
    cnt_d   = cnt_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    if (state_q == ST_IDLE) begin
      if (pop) begin
        shift_d = head;
        cnt_d   = div_q;
        idx_d   = 3'd0;
      end
    end else if (bit_end) begin
      cnt_d = div_q;
      if (state_q == ST_DATA) begin
        shift_d = {1'b0, shift_q[7:1]};
        idx_d   = idx_q + 3'd1;
      end
    end else begin
      cnt_d = cnt_q - 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= 16'd0;
      shift_q <= 8'd0;
      idx_q   <= 3'd0;
      tx_q    <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
    end
  end

  assign op_uart_tx = tx_q;

  // Combinational read port
  logic [31:0] rd_data;
  always_comb begin
    rd_data = 32'd0;
    if (aligned) begin
      case (word)
        2'd1:    rd_data = {16'd0, 8'(count_q), 4'd0, ovf_q, empty, busy, ~full};
        2'd2:    rd_data = {16'd0, div_q};
        default: rd_data = 32'd0;
      endcase
    end
  end

  assign bus.op_sel          = in_win;
  assign bus.op_data_valid   = in_win & bus.ip_data_rd;
  assign bus.op_data_to_proc = in_win ? rd_data : 32'd0;

`ifdef _SIM_
  always @(posedge clk) begin
    if (!reset && push_ok) $write("%c", bus.ip_data_from_proc[7:0]);
  end
`endif

endmodule

// File: tb/tb_mmio_uart.sv
// Directed self-checking bench for mmio_uart.
module tb_mmio_uart;
  localparam logic [31:0] BASE = 32'h0000_0054;

  logic clk = 1'b0;
  logic reset;
  logic tx;
  always #5 clk = ~clk;

  mmio_uart_if bus();

  mmio_uart #(.BASE_ADDR(BASE), .FIFO_DEPTH(8), .DEFAULT_DIVISOR(16'd433)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .op_uart_tx (tx)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Cycle counter and serial-line receiver (samples each bit at its first negedge)
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        mon_en = 1'b0;
  int          mon_p  = 1;
  logic [7:0]  rx_q[$];
  int unsigned st_q[$];
  int          frm_err = 0;

  initial begin
    logic [7:0]  b;
    int unsigned s;
    forever begin
      @(negedge clk);
      if (mon_en && tx === 1'b0) begin
        s = cyc;
        for (int i = 0; i < 8; i++) begin
          repeat (mon_p) @(negedge clk);
          b[i] = tx;
        end
        repeat (mon_p) @(negedge clk);
        if (tx !== 1'b1) frm_err++;
        rx_q.push_back(b);
        st_q.push_back(s);
      end
    end
  end

  // Write commits on the next posedge; returns at the following negedge
  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    bus.ip_data_addr      = a;
    bus.ip_data_from_proc = d;
    bus.ip_data_mask      = m;
    bus.ip_data_wr        = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.ip_data_wr = 1'b0;
  endtask

  task automatic bus_rd(input logic [31:0] a, output logic [31:0] d, output logic v, output logic s);
    bus.ip_data_addr = a;
    bus.ip_data_rd   = 1'b1;
    #1;
    d = bus.op_data_to_proc;
    v = bus.op_data_valid;
    s = bus.op_sel;
    bus.ip_data_rd = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] d;
    logic        v, s, found, low_seen;
    logic [9:0]  exp_bits;

    bus.ip_data_addr      = 32'd0;
    bus.ip_data_wr        = 1'b0;
    bus.ip_data_mask      = 4'd0;
    bus.ip_data_from_proc = 32'd0;
    bus.ip_data_rd        = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("tx_in_reset", 32'(tx), 32'd1);
    reset = 1'b0;

    // Reset state
    bus_rd(BASE + 32'd4, d, v, s);
    check("status_rst", d, 32'h5);
    check("valid_sel", 32'(v), 32'd1);
    bus_rd(BASE + 32'd8, d, v, s);
    check("div_rst", d, 32'd433);
    bus_rd(BASE, d, v, s);
    check("txdata_rd0", d, 32'd0);
    check("tx_idle", 32'(tx), 32'd1);

    // Per-lane divisor write: only the high byte changes (433 = 0x01B1)
    bus_wr(BASE + 32'd8, 32'h0000_FFFF, 4'b0010);
    bus_rd(BASE + 32'd8, d, v, s);
    check("div_lane1", d, 32'h0000_FFB1);
    bus_wr(BASE + 32'd8, 32'd3, 4'b0011);
    bus_rd(BASE + 32'd8, d, v, s);
    check("div_3", d, 32'd3);

    // 0xA5 at 4 clk/bit: start, LSB-first data, stop
    exp_bits = 10'b11_0100_1010;
    bus_wr(BASE, 32'hA5, 4'b0001);
    found = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (tx === 1'b0) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("a5_start_seen", 32'(found), 32'd1);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("a5_bit%0d", i), 32'(tx), 32'(exp_bits[i]));
      if (i == 4) begin
        bus_rd(BASE + 32'd4, d, v, s);
        check("a5_busy_mid", 32'(d[1]), 32'd1);
      end
      repeat (4) @(negedge clk);
    end
    bus_rd(BASE + 32'd4, d, v, s);
    check("a5_status_after", d, 32'h5);

    // Three frames at 1 clk/bit, 11 cycles start-to-start
    bus_wr(BASE + 32'd8, 32'd0, 4'b0011);
    mon_p = 1;
    rx_q.delete();
    st_q.delete();
    mon_en = 1'b1;
    bus_wr(BASE, 32'h41, 4'b0001);
    bus_wr(BASE, 32'h42, 4'b0001);
    bus_wr(BASE, 32'h43, 4'b0001);
    repeat (60) @(negedge clk);
    check("abc_count", 32'(rx_q.size()), 32'd3);
    if (rx_q.size() == 3) begin
      check("abc_0", 32'(rx_q[0]), 32'h41);
      check("abc_1", 32'(rx_q[1]), 32'h42);
      check("abc_2", 32'(rx_q[2]), 32'h43);
      check("abc_gap01", st_q[1] - st_q[0], 32'd11);
      check("abc_gap12", st_q[2] - st_q[1], 32'd11);
    end

    // Fill: 9 back-to-back pushes, the first already popped -> 8 queued
    rx_q.delete();
    st_q.delete();
    for (int i = 0; i < 9; i++) bus_wr(BASE, 32'h10 + 32'(i), 4'b0001);
    bus_rd(BASE + 32'd4, d, v, s);
    check("full_status", d, 32'h0000_0802);
    bus_wr(BASE, 32'h19, 4'b0001);
    bus_rd(BASE + 32'd4, d, v, s);
    check("ovf_status", d, 32'h0000_080A);
    bus_wr(BASE + 32'd4, 32'h8, 4'b0001);
    bus_rd(BASE + 32'd4, d, v, s);
    check("ovf_clr_status", d, 32'h0000_0802);
    repeat (130) @(negedge clk);
    check("fill_rx_count", 32'(rx_q.size()), 32'd9);
    if (rx_q.size() == 9) begin
      for (int i = 0; i < 9; i++) check($sformatf("fill_rx%0d", i), 32'(rx_q[i]), 32'h10 + 32'(i));
    end
    check("frame_errors", 32'(frm_err), 32'd0);
    bus_rd(BASE + 32'd4, d, v, s);
    check("fill_drained", d, 32'h5);
    mon_en = 1'b0;

    // Reset in the middle of the DATA state
    bus_wr(BASE + 32'd8, 32'd3, 4'b0011);
    bus_wr(BASE, 32'h5A, 4'b0001);
    bus_wr(BASE, 32'h33, 4'b0001);
    repeat (10) @(negedge clk);
    bus_rd(BASE + 32'd4, d, v, s);
    check("pre_reset_status", d, 32'h0000_0103);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("tx_after_reset", 32'(tx), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    bus_rd(BASE + 32'd4, d, v, s);
    check("status_after_reset", d, 32'h5);
    low_seen = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (tx !== 1'b1) low_seen = 1'b1;
    end
    check("no_frame_after_reset", 32'(low_seen), 32'd0);

    // Out-of-window accesses
    bus_wr(BASE + 32'd8, 32'd0, 4'b0011);
    bus_rd(BASE + 32'd12, d, v, s);
    check("b12_sel", 32'(s), 32'd0);
    check("b12_valid", 32'(v), 32'd0);
    check("b12_data", d, 32'd0);
    bus_wr(BASE + 32'd12, 32'h77, 4'b1111);
    bus_rd(32'h0000_0000, d, v, s);
    check("dmem_sel", 32'(s), 32'd0);
    check("dmem_data", d, 32'd0);
    bus_wr(32'h0000_0000, 32'h77, 4'b1111);
    bus_wr(BASE - 32'd4, 32'h77, 4'b1111);
    bus_rd(BASE + 32'd4, d, v, s);
    check("oow_status", d, 32'h5);
    low_seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (tx !== 1'b1) low_seen = 1'b1;
    end
    check("oow_no_tx", 32'(low_seen), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
